// File: rtl/mc_bus_bridge.sv
// MCU external-bus slave: synchronises ce/we/oe strobes, decodes bus writes
// into a tagged inbound FIFO and serves bus reads from an outbound FIFO or status.
module mc_bus_bridge #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADD_WIDTH   = 6,
   parameter int IN_DEPTH    = 16,
   parameter int OUT_DEPTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_DATA   = 0,
   parameter int ADDR_CMD    = 1,
   parameter int ADDR_STATUS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mc_ce_n,
   input  logic                  mc_we_n,
   input  logic                  mc_oe_n,
   input  logic [ADD_WIDTH-1:0]  mc_add,
   input  logic [DATA_WIDTH-1:0] mc_data_in,
   output logic [DATA_WIDTH-1:0] mc_data_out,
   output logic                  mc_data_oe,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_is_command,
   output logic [DATA_WIDTH-1:0] cmd_word,
   input  logic                  rsp_valid,
   output logic                  rsp_ready,
   input  logic [DATA_WIDTH-1:0] rsp_data,
   input  logic                  fifo_clear,
   output logic                  in_full,
   output logic                  out_nempty
);
   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam int LAST   = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] ce_sync, we_sync, oe_sync;
   logic                   we_prev, oe_prev;
   logic                   bus_sel, we_rise, oe_fall, oe_rise;
   logic                   is_data, is_cmd, is_status;

   logic [DATA_WIDTH:0]    in_mem [IN_DEPTH];
   logic [IN_AW-1:0]       in_wr_ptr, in_rd_ptr;
   logic [IN_AW:0]         in_count;
   logic                   in_wr_req, in_push, in_pop;

   logic [DATA_WIDTH-1:0]  out_mem [OUT_DEPTH];
   logic [OUT_AW-1:0]      out_wr_ptr, out_rd_ptr;
   logic [OUT_AW:0]        out_count;
   logic                   out_full, out_push, out_pop;

   logic                   overflow, underflow, rd_pending;
   logic [DATA_WIDTH-1:0]  status_word;
   logic [31:0]            out_count_ext;

   assign bus_sel   = ~ce_sync[LAST];
   assign we_rise   = bus_sel & we_sync[LAST] & ~we_prev;
   assign oe_fall   = bus_sel & ~oe_sync[LAST] & oe_prev;
   assign oe_rise   = oe_sync[LAST] & ~oe_prev;
   assign is_data   = (mc_add == ADD_WIDTH'(ADDR_DATA));
   assign is_cmd    = (mc_add == ADD_WIDTH'(ADDR_CMD));
   assign is_status = (mc_add == ADD_WIDTH'(ADDR_STATUS));

   assign in_full        = (in_count == (IN_AW+1)'(IN_DEPTH));
   assign cmd_valid      = (in_count != '0);
   assign cmd_word       = in_mem[in_rd_ptr][DATA_WIDTH-1:0];
   assign cmd_is_command = in_mem[in_rd_ptr][DATA_WIDTH];
   assign in_wr_req      = we_rise & (is_data | is_cmd);
   assign in_pop         = cmd_valid & cmd_ready;
   assign in_push        = in_wr_req & (~in_full | in_pop);

   assign out_full   = (out_count == (OUT_AW+1)'(OUT_DEPTH));
   assign out_nempty = (out_count != '0);
   // The pop is decided by registered strobe state only, so advertising ready
   // when a pop frees a slot in the same cycle creates no combinational loop.
   assign out_pop    = oe_rise & rd_pending & out_nempty;
   assign rsp_ready  = ~out_full | out_pop;
   assign out_push   = rsp_valid & rsp_ready;

   assign out_count_ext = 32'(out_count);
   always_comb begin
      status_word       = '0;
      status_word[0]    = in_full;
      status_word[1]    = (in_count == '0);
      status_word[2]    = out_nempty;
      status_word[3]    = overflow;
      status_word[4]    = underflow;
      status_word[15:8] = (out_count_ext > 32'd255) ? 8'hFF : out_count_ext[7:0];
   end

   always_ff @(posedge clk) begin
      if (in_push && !fifo_clear)
         in_mem[in_wr_ptr] <= {is_cmd, mc_data_in};
      if (out_push && !fifo_clear)
         out_mem[out_wr_ptr] <= rsp_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ce_sync     <= '1;
         we_sync     <= '1;
         oe_sync     <= '1;
         we_prev     <= 1'b1;
         oe_prev     <= 1'b1;
         in_wr_ptr   <= '0;
         in_rd_ptr   <= '0;
         in_count    <= '0;
         out_wr_ptr  <= '0;
         out_rd_ptr  <= '0;
         out_count   <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
         rd_pending  <= 1'b0;
         mc_data_out <= '0;
         mc_data_oe  <= 1'b0;
      end else begin
         ce_sync <= {ce_sync[SYNC_STAGES-2:0], mc_ce_n};
         we_sync <= {we_sync[SYNC_STAGES-2:0], mc_we_n};
         oe_sync <= {oe_sync[SYNC_STAGES-2:0], mc_oe_n};
         we_prev <= we_sync[LAST];
         oe_prev <= oe_sync[LAST];

         if (oe_fall) begin
            mc_data_oe <= 1'b1;
            if (is_data)
               mc_data_out <= out_nempty ? out_mem[out_rd_ptr] : '0;
            else if (is_status)
               mc_data_out <= status_word;
            else
               mc_data_out <= '0;
         end else if (oe_rise) begin
            mc_data_oe <= 1'b0;
         end

         if (fifo_clear) begin
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            rd_pending <= 1'b0;
         end else begin
            if (in_push) in_wr_ptr <= in_wr_ptr + IN_AW'(1);
            if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_AW'(1);
            if (in_push && !in_pop)      in_count <= in_count + (IN_AW+1)'(1);
            else if (!in_push && in_pop) in_count <= in_count - (IN_AW+1)'(1);
            if (in_wr_req && in_full && !in_pop) overflow <= 1'b1;

            if (out_push) out_wr_ptr <= out_wr_ptr + OUT_AW'(1);
            if (out_pop)  out_rd_ptr <= out_rd_ptr + OUT_AW'(1);
            if (out_push && !out_pop)      out_count <= out_count + (OUT_AW+1)'(1);
            else if (!out_push && out_pop) out_count <= out_count - (OUT_AW+1)'(1);

            if (oe_fall) begin
               rd_pending <= is_data & out_nempty;
               if (is_data && !out_nempty) underflow <= 1'b1;
            end else if (oe_rise) begin
               rd_pending <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_mc_bus_bridge.sv
// Scoreboard bench for mc_bus_bridge: expected cmd words and bus read data are
// queued by the stimulus and compared by independent monitors.
module tb_mc_bus_bridge;
   localparam int DW = 16;
   localparam int AW = 6;
   localparam int ID = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mc_ce_n = 1'b1, mc_we_n = 1'b1, mc_oe_n = 1'b1;
   logic [AW-1:0] mc_add = '0;
   logic [DW-1:0] mc_data_in = '0;
   logic [DW-1:0] mc_data_out;
   logic          mc_data_oe;
   logic          cmd_valid, cmd_is_command;
   logic          cmd_ready = 1'b0;
   logic [DW-1:0] cmd_word;
   logic          rsp_valid = 1'b0;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data = '0;
   logic          fifo_clear = 1'b0;
   logic          in_full, out_nempty;

   int unsigned checks = 0;
   int unsigned failures = 0;
   logic [DW:0]   cmd_q [$];
   logic [DW-1:0] rd_q  [$];
   logic          oe_seen = 1'b0;

   mc_bus_bridge #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .IN_DEPTH(ID), .OUT_DEPTH(16),
                   .SYNC_STAGES(2), .ADDR_DATA(0), .ADDR_CMD(1), .ADDR_STATUS(2)) dut (
      .clk(clk), .rst(rst), .mc_ce_n(mc_ce_n), .mc_we_n(mc_we_n), .mc_oe_n(mc_oe_n),
      .mc_add(mc_add), .mc_data_in(mc_data_in), .mc_data_out(mc_data_out),
      .mc_data_oe(mc_data_oe), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_is_command(cmd_is_command), .cmd_word(cmd_word), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .fifo_clear(fifo_clear),
      .in_full(in_full), .out_nempty(out_nempty));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Inbound stream monitor: every accepted head must match the oldest expected word.
   always @(negedge clk) begin
      if (rst && cmd_valid && cmd_ready) begin
         if (cmd_q.size() == 0) check("cmd_unexpected", {cmd_is_command, cmd_word}, 32'hDEAD);
         else check("cmd_stream", {cmd_is_command, cmd_word}, cmd_q.pop_front());
      end
   end

   // Bus read monitor: compare data when the drive enable first rises.
   always @(negedge clk) begin
      if (!rst) oe_seen = 1'b0;
      else begin
         if (mc_data_oe && !oe_seen) begin
            if (rd_q.size() == 0) check("rd_unexpected", mc_data_out, 32'hDEAD);
            else check("rd_data", mc_data_out, rd_q.pop_front());
         end
         oe_seen = mc_data_oe;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_push);
      mc_ce_n = 1'b0; mc_add = a; mc_data_in = d;
      tick(1);
      mc_we_n = 1'b0;
      tick(6);
      if (expect_push) cmd_q.push_back({(a == AW'(1)), d});
      mc_we_n = 1'b1;
      tick(4);
      mc_ce_n = 1'b1;
      tick(1);
   endtask

   task automatic bus_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
      mc_ce_n = 1'b0; mc_add = a;
      tick(1);
      rd_q.push_back(exp);
      mc_oe_n = 1'b0;
      tick(6);
      mc_oe_n = 1'b1;
      tick(4);
      mc_ce_n = 1'b1;
      tick(1);
   endtask

   task automatic rsp_push(input logic [DW-1:0] d);
      rsp_valid = 1'b1; rsp_data = d;
      check("rsp_ready", rsp_ready, 1);
      tick(1);
      rsp_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int unsigned n = 0;
      cmd_ready = 1'b1;
      while (cmd_q.size() != 0 && n < 200) begin tick(1); n++; end
      tick(2);
      check(name, cmd_q.size(), 0);
   endtask

   task automatic clear_fifos();
      fifo_clear = 1'b1; tick(1); fifo_clear = 1'b0; tick(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      check("rst_data_out", mc_data_out, 0);
      check("rst_data_oe", mc_data_oe, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_rsp_ready", rsp_ready, 1);
      check("rst_in_full", in_full, 0);
      check("rst_out_nempty", out_nempty, 0);
      rst = 1'b1;
      tick(3);

      // basic command/data writes
      cmd_ready = 1'b1;
      bus_write(1, 16'h0082, 1);
      bus_write(0, 16'h00FF, 1);
      drain("t1_drain");
      check("t1_cmd_valid_low", cmd_valid, 0);
      bus_write(5, 16'h7777, 0);
      check("t1_bad_addr_ignored", cmd_valid, 0);

      // overflow with core stalled
      cmd_ready = 1'b0;
      for (int i = 0; i <= ID; i++) bus_write(0, DW'(16'h0100 + i), (i < ID));
      check("t2_in_full", in_full, 1);
      bus_read(2, 16'h0009);
      drain("t2_drain");
      check("t2_cmd_valid_low", cmd_valid, 0);
      clear_fifos();

      // outbound reads with underflow
      rsp_push(16'hA5A5);
      rsp_push(16'h1234);
      check("t3_out_nempty_2", out_nempty, 1);
      bus_read(0, 16'hA5A5);
      check("t3_out_nempty_1", out_nempty, 1);
      bus_read(0, 16'h1234);
      check("t3_out_nempty_0", out_nempty, 0);
      bus_read(0, 16'h0000);
      bus_read(2, 16'h0012);
      bus_read(9, 16'h0000);

      // outbound count in status
      clear_fifos();
      rsp_push(16'h0001); rsp_push(16'h0002); rsp_push(16'h0003);
      bus_read(2, 16'h0306);

      // fifo_clear overlapping a bus push
      cmd_ready = 1'b0;
      mc_ce_n = 1'b0; mc_add = 0; mc_data_in = 16'hBEEF;
      tick(1);
      mc_we_n = 1'b0;
      tick(6);
      mc_we_n = 1'b1;
      fifo_clear = 1'b1;
      tick(6);
      fifo_clear = 1'b0;
      mc_ce_n = 1'b1;
      tick(2);
      check("t5_cmd_valid", cmd_valid, 0);
      check("t5_out_nempty", out_nempty, 0);
      bus_read(2, 16'h0002);

      // reset during a held write strobe
      mc_ce_n = 1'b0; mc_add = 1; mc_data_in = 16'h4321;
      tick(1);
      mc_we_n = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(3);
      check("t6_rst_data_out", mc_data_out, 0);
      rst = 1'b1;
      tick(8);
      check("t6_no_push", cmd_valid, 0);
      cmd_q.push_back({1'b1, 16'h4321});
      mc_we_n = 1'b1;
      tick(4);
      mc_ce_n = 1'b1;
      check("t6_push_seen", cmd_valid, 1);
      drain("t6_drain");

      tick(5);
      check("rd_queue_empty", rd_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
